// File: rtl/svc_rv_mmio_pkg.sv
// Shared register map for the RV MMIO UART bridge: word indices and STATUS bit
// positions, so that firmware headers and tests use the same values.
package svc_rv_mmio_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_NEMPTY = 2;
  localparam int STAT_RX_FULL   = 3;
  localparam int STAT_TX_OVF    = 4;
  localparam int STAT_RX_OVF    = 5;

endpackage

// File: rtl/svc_rv_mmio_fifo.sv
// Synchronous byte FIFO with AW+1 bit pointers, a combinational head read and
// a rejected push when full / ignored pop when empty.
module svc_rv_mmio_fifo
  import svc_rv_mmio_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty     = (wptr_r == rptr_r);
  assign level     = wptr_r - rptr_r;
  assign head      = mem_r[rptr_r[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer advance and storage write; full/empty come from start-of-cycle pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r[AW-1:0]] <= din;
        wptr_r                <= wptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/svc_rv_mmio_uart_bridge.sv
// MMIO target bridging CPU loads/stores to a TX and an RX byte stream through
// two FIFOs, with polled status, occupancy levels and sticky overflow flags.
module svc_rv_mmio_uart_bridge
  import svc_rv_mmio_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        m_tx_valid,
  output logic [7:0]  m_tx_data,
  input  logic        m_tx_ready,
  input  logic        s_rx_valid,
  input  logic [7:0]  s_rx_data,
  output logic        s_rx_ready
);

  logic [1:0]       rd_idx_s;
  logic [1:0]       wr_idx_s;
  logic             wr_byte0_s;
  logic             tx_push_s;
  logic             tx_pop_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic [FIFO_AW:0] tx_level_s;
  logic             rx_push_s;
  logic             rx_pop_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic [FIFO_AW:0] rx_level_s;
  logic [7:0]       rx_head_s;
  logic             tx_ovf_r;
  logic             rx_ovf_r;
  logic             tx_ovf_set_s;
  logic             rx_ovf_set_s;
  logic             tx_ovf_clr_s;
  logic             rx_ovf_clr_s;
  logic [31:0]      status_s;
  logic [31:0]      level_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign rd_idx_s   = io_raddr[3:2];
  assign wr_idx_s   = io_waddr[3:2];
  assign wr_byte0_s = io_wen && io_wstrb[0];

  assign tx_push_s  = wr_byte0_s && (wr_idx_s == REG_TXDATA);
  assign tx_pop_s   = m_tx_valid && m_tx_ready;
  assign m_tx_valid = !tx_empty_s && !rst;

  // The source holds a refused RX byte, so overflow only flags the stall.
  assign s_rx_ready = !rx_full_s && !rst;
  assign rx_push_s  = s_rx_valid && s_rx_ready;
  assign rx_pop_s   = io_ren && (rd_idx_s == REG_RXDATA) && !rx_empty_s;

  assign tx_ovf_set_s = tx_push_s && tx_full_s;
  assign rx_ovf_set_s = s_rx_valid && rx_full_s;
  assign tx_ovf_clr_s = wr_byte0_s && (wr_idx_s == REG_STATUS) && io_wdata[STAT_TX_OVF];
  assign rx_ovf_clr_s = wr_byte0_s && (wr_idx_s == REG_STATUS) && io_wdata[STAT_RX_OVF];

  assign unused_s = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                      io_wdata[31:8], io_wstrb[3:1]};

  svc_rv_mmio_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_s),
    .din   (io_wdata[7:0]),
    .pop   (tx_pop_s),
    .head  (m_tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .level (tx_level_s)
  );

  svc_rv_mmio_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_s),
    .din   (s_rx_data),
    .pop   (rx_pop_s),
    .head  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .level (rx_level_s)
  );

  // Read data mux over the register map, built from start-of-cycle state.
  always_comb begin
    status_s                      = 32'd0;
    status_s[STAT_TX_FULL]        = tx_full_s;
    status_s[STAT_TX_EMPTY]       = tx_empty_s;
    status_s[STAT_RX_NEMPTY]      = !rx_empty_s;
    status_s[STAT_RX_FULL]        = rx_full_s;
    status_s[STAT_TX_OVF]         = tx_ovf_r;
    status_s[STAT_RX_OVF]         = rx_ovf_r;
    level_s                       = 32'd0;
    level_s[FIFO_AW:0]            = tx_level_s;
    level_s[16+FIFO_AW:16]        = rx_level_s;
    case (rd_idx_s)
      REG_TXDATA: rdata_s = 32'd0;
      REG_RXDATA: rdata_s = rx_empty_s ? 32'd0 : {1'b1, 23'd0, rx_head_s};
      REG_STATUS: rdata_s = status_s;
      REG_LEVEL:  rdata_s = level_s;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Sticky overflow flags (set wins over clear) and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_r <= 1'b0;
      rx_ovf_r <= 1'b0;
      io_rdata <= 32'd0;
    end else begin
      tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~tx_ovf_clr_s);
      rx_ovf_r <= rx_ovf_set_s | (rx_ovf_r & ~rx_ovf_clr_s);
      if (io_ren) begin
        io_rdata <= rdata_s;
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_mmio_uart_bridge.sv
// Scoreboard bench for svc_rv_mmio_uart_bridge: stimulus pushes expected read
// data and TX bytes into queues, monitors pop and compare on DUT outputs.
module tb_svc_rv_mmio_uart_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        m_tx_valid;
  logic [7:0]  m_tx_data;
  logic        m_tx_ready;
  logic        s_rx_valid;
  logic [7:0]  s_rx_data;
  logic        s_rx_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic        rd_fire = 1'b0;

  svc_rv_mmio_uart_bridge #(.FIFO_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_ren     (io_ren),
    .io_raddr   (io_raddr),
    .io_rdata   (io_rdata),
    .io_wen     (io_wen),
    .io_waddr   (io_waddr),
    .io_wdata   (io_wdata),
    .io_wstrb   (io_wstrb),
    .m_tx_valid (m_tx_valid),
    .m_tx_data  (m_tx_data),
    .m_tx_ready (m_tx_ready),
    .s_rx_valid (s_rx_valid),
    .s_rx_data  (s_rx_data),
    .s_rx_ready (s_rx_ready)
  );

  always #5 clk = ~clk;

  // A load accepted at this edge (outside reset) presents data after the edge.
  always @(posedge clk) rd_fire <= io_ren && !rst;

  // Read-data monitor.
  always @(negedge clk) begin
    if (rd_fire) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rdata_unexpected: got %08h, no read expected", io_rdata);
      end else begin
        logic [31:0] exp;
        exp = rd_q.pop_front();
        if (io_rdata !== exp) begin
          n_err++;
          $display("FAIL rdata: got %08h, expected %08h", io_rdata, exp);
        end
      end
    end
  end

  // TX stream monitor: one byte per valid&&ready handshake.
  always @(negedge clk) begin
    if (m_tx_valid === 1'b1 && m_tx_ready === 1'b1) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %02h, no byte expected", m_tx_data);
      end else begin
        logic [7:0] exp;
        exp = tx_q.pop_front();
        if (m_tx_data !== exp) begin
          n_err++;
          $display("FAIL tx_data: got %02h, expected %02h", m_tx_data, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d, input bit exp_tx);
    io_wen   = 1'b1;
    io_waddr = {28'd0, idx, 2'b00};
    io_wdata = d;
    io_wstrb = 4'hF;
    if (exp_tx) tx_q.push_back(d[7:0]);
    cyc();
    io_wen   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp);
    io_ren   = 1'b1;
    io_raddr = {28'd0, idx, 2'b00};
    rd_q.push_back(exp);
    cyc();
    io_ren   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    io_ren     = 1'b0;
    io_raddr   = 32'd0;
    io_wen     = 1'b0;
    io_waddr   = 32'd0;
    io_wdata   = 32'd0;
    io_wstrb   = 4'h0;
    m_tx_ready = 1'b0;
    s_rx_valid = 1'b0;
    s_rx_data  = 8'h00;

    // Reset state
    cyc();
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_rx_ready", {31'd0, s_rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, m_tx_valid}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_rx_ready", {31'd0, s_rx_ready}, 32'd1);
    rd(2'd2, 32'h0000_0002);
    rd(2'd3, 32'h0000_0000);

    // Three TX bytes, then drain on consecutive cycles
    wr(2'd0, 32'h41, 1'b1);
    wr(2'd0, 32'h42, 1'b1);
    wr(2'd0, 32'h43, 1'b1);
    rd(2'd3, 32'h0000_0003);
    m_tx_ready = 1'b1;
    repeat (3) cyc();
    chk("tx_drained_valid", {31'd0, m_tx_valid}, 32'd0);
    m_tx_ready = 1'b0;
    cyc();

    // 17 writes: 17th dropped, overflow flag then cleared
    for (int i = 0; i < 17; i++) wr(2'd0, 32'(8'h60 + i), i < 16);
    rd(2'd2, 32'h0000_0011);
    wr(2'd2, 32'h0000_0010, 1'b0);
    rd(2'd2, 32'h0000_0001);
    rd(2'd3, 32'h0000_0010);
    m_tx_ready = 1'b1;
    repeat (16) cyc();
    m_tx_ready = 1'b0;
    chk("tx_empty_after_16", {31'd0, m_tx_valid}, 32'd0);

    // Single RX byte
    s_rx_valid = 1'b1;
    s_rx_data  = 8'h5A;
    cyc();
    s_rx_valid = 1'b0;
    rd(2'd3, 32'h0001_0000);
    rd(2'd1, 32'h8000_005A);
    rd(2'd3, 32'h0000_0000);
    rd(2'd1, 32'h0000_0000);

    // Fill RX, hold 0x99 against a full FIFO
    for (int i = 0; i < 16; i++) begin
      s_rx_valid = 1'b1;
      s_rx_data  = 8'(8'h80 + i);
      cyc();
    end
    s_rx_data = 8'h99;
    cyc();
    chk("rx_full_ready", {31'd0, s_rx_ready}, 32'd0);
    rd(2'd2, 32'h0000_002E);
    rd(2'd1, 32'h8000_0080);
    chk("rx_ready_after_pop", {31'd0, s_rx_ready}, 32'd1);
    cyc();
    s_rx_valid = 1'b0;
    chk("rx_full_again", {31'd0, s_rx_ready}, 32'd0);
    for (int i = 1; i < 16; i++) rd(2'd1, 32'h8000_0080 + 32'(i));
    rd(2'd1, 32'h8000_0099);
    wr(2'd2, 32'h0000_0020, 1'b0);
    rd(2'd2, 32'h0000_0002);

    // Same-cycle TX pop and push with three entries held
    wr(2'd0, 32'h11, 1'b1);
    wr(2'd0, 32'h22, 1'b1);
    wr(2'd0, 32'h33, 1'b1);
    m_tx_ready = 1'b1;
    wr(2'd0, 32'h44, 1'b1);
    m_tx_ready = 1'b0;
    rd(2'd3, 32'h0000_0003);
    m_tx_ready = 1'b1;
    repeat (3) cyc();
    m_tx_ready = 1'b0;

    // Reset mid-traffic with both FIFOs partly full and a read in flight
    wr(2'd0, 32'h55, 1'b0);
    wr(2'd0, 32'h66, 1'b0);
    s_rx_valid = 1'b1;
    s_rx_data  = 8'h77;
    repeat (2) cyc();
    s_rx_valid = 1'b0;
    rd(2'd3, 32'h0002_0002);
    io_ren   = 1'b1;
    io_raddr = 32'h0000_0004;
    rst      = 1'b1;
    cyc();
    io_ren   = 1'b0;
    rst      = 1'b0;
    chk("midrst_rdata", io_rdata, 32'd0);
    chk("midrst_tx_valid", {31'd0, m_tx_valid}, 32'd0);
    rd(2'd3, 32'h0000_0000);
    rd(2'd2, 32'h0000_0002);

    repeat (3) cyc();
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
